gem_fiber_in: RTL and testbench

Receive-side deframer for the GEM trigger fiber link. It consumes the 32-bit, 80 MHz word stream from the GTX receiver after 8b10b decode, and recognises the two-word GEM frame:
- high word: data[55:24], isk 0000;
- low word: {data[23:0], separator K-code}, isk 0001.

It checks the BC→F7→FB→FD separator rotation, runs a hunt/sync/lock state machine, and presents reassembled 56-bit cluster data with overflow and bunch-sequence flags to downstream trigger logic.

---
 rtl/gem_fiber_pkg.sv | 33 +++
 rtl/gem_rx_word_class.sv | 45 ++++
 rtl/gem_fiber_in.sv | 165 ++++++++++++++++
 tb/tb_gem_fiber_in.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gem_fiber_pkg.sv
// Shared constants, word/state types and separator helpers for the GEM fiber deframer.
package gem_fiber_pkg;

  localparam logic [7:0]  K_BC      = 8'hBC;
  localparam logic [7:0]  K_F7      = 8'hF7;
  localparam logic [7:0]  K_FB      = 8'hFB;
  localparam logic [7:0]  K_FD      = 8'hFD;
  localparam logic [7:0]  K_FC      = 8'hFC;
  localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
  localparam logic [3:0]  IDLE_ISK  = 4'b0101;

  typedef enum logic [1:0] {WC_IDLE, WC_HIGH, WC_LOW, WC_BAD} word_class_e;
  typedef enum logic [1:0] {ST_HUNT, ST_SYNC, ST_LOCK} state_e;

  // FC carries no sequence position of its own; callers handle it separately.
  function automatic logic [1:0] sep_to_idx(input logic [7:0] sep);
    case (sep)
      K_F7:    return 2'd1;
      K_FB:    return 2'd2;
      K_FD:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] idx_succ(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  function automatic logic is_sep(input logic [7:0] b);
    return (b == K_BC) || (b == K_F7) || (b == K_FB) || (b == K_FD) || (b == K_FC);
  endfunction

endpackage

// File: rtl/gem_rx_word_class.sv
// Registers one receive word and classifies it as IDLE/HIGH/LOW/BAD; one cycle latency, no backpressure.
module gem_rx_word_class
  import gem_fiber_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_isk,
  input  logic        rx_err,
  output word_class_e wclass,
  output logic [7:0]  byte0,
  output logic [31:0] word
);

  logic [3:0] isk_q;
  logic       err_q;

  // The error flag resets high so the first word after reset is seen as BAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word  <= '0;
      isk_q <= '0;
      err_q <= 1'b1;
    end else begin
      word  <= rx_data;
      isk_q <= rx_isk;
      err_q <= rx_err;
    end
  end

  always_comb begin
    byte0 = word[7:0];
    if (err_q)
      wclass = WC_BAD;
    else if (word == IDLE_WORD && isk_q == IDLE_ISK)
      wclass = WC_IDLE;
    else if (isk_q == 4'b0000)
      wclass = WC_HIGH;
    else if (isk_q == 4'b0001 && is_sep(word[7:0]))
      wclass = WC_LOW;
    else
      wclass = WC_BAD;
  end

endmodule

// File: rtl/gem_fiber_in.sv
// GEM fiber deframer: phase tracking, separator check, HUNT/SYNC/LOCK and output registers.
// LOW word at the pins to DATA_VALID is two cycles; no backpressure, one frame per two cycles.
module gem_fiber_in
  import gem_fiber_pkg::*;
#(
  parameter int SYNC_FRAMES = 4,
  parameter int LOSS_FRAMES = 3
) (
  input  logic        TRG_CLK80,
  input  logic        TRG_RST_N,
  input  logic [31:0] RX_DATA,
  input  logic [3:0]  RX_ISK,
  input  logic        RX_ERR,
  output logic [55:0] GEM_DATA,
  output logic        GEM_OVERFLOW,
  output logic [1:0]  BX_SEQ,
  output logic        DATA_VALID,
  output logic        LOCKED,
  output logic        IDLE,
  output logic        SEP_ERR,
  output logic [15:0] ERR_CNT
);

  localparam logic [3:0] SYNC_N = 4'(SYNC_FRAMES);
  localparam logic [3:0] LOSS_N = 4'(LOSS_FRAMES);

  word_class_e wclass;
  logic [7:0]  byte0;
  logic [31:0] word;

  gem_rx_word_class u_word_class (
    .clk    (TRG_CLK80),
    .rst_n  (TRG_RST_N),
    .rx_data(RX_DATA),
    .rx_isk (RX_ISK),
    .rx_err (RX_ERR),
    .wclass (wclass),
    .byte0  (byte0),
    .word   (word)
  );

  state_e      state;
  logic        expect_low;
  logic [1:0]  exp_idx;
  logic [31:0] hi_word;
  logic [3:0]  good_cnt;
  logic [3:0]  bad_cnt;

  logic       sep_fc;
  logic [1:0] sep_idx;
  logic       frame_done;
  logic       frame_bad;
  logic       sep_mis;

  always_comb begin
    sep_fc     = (byte0 == K_FC);
    sep_idx    = sep_to_idx(byte0);
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    sep_mis    = 1'b0;
    case (wclass)
      WC_HIGH: frame_bad = expect_low;
      WC_LOW: begin
        if (expect_low) begin
          frame_done = 1'b1;
          sep_mis    = !sep_fc && (sep_idx != exp_idx);
          frame_bad  = sep_mis;
        end else begin
          frame_bad = 1'b1;
        end
      end
      WC_BAD:  frame_bad = 1'b1;
      default: frame_bad = 1'b0;
    endcase
  end

  always_ff @(posedge TRG_CLK80) begin
    if (!TRG_RST_N) begin
      state        <= ST_HUNT;
      expect_low   <= 1'b0;
      exp_idx      <= '0;
      hi_word      <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      GEM_DATA     <= '0;
      GEM_OVERFLOW <= 1'b0;
      BX_SEQ       <= '0;
      DATA_VALID   <= 1'b0;
      LOCKED       <= 1'b0;
      IDLE         <= 1'b0;
      SEP_ERR      <= 1'b0;
      ERR_CNT      <= '0;
    end else begin
      DATA_VALID <= 1'b0;
      SEP_ERR    <= 1'b0;
      IDLE       <= (wclass == WC_IDLE);
      // Any HIGH (even an unexpected one) becomes the pending half of the next frame.
      expect_low <= (wclass == WC_HIGH);
      if (wclass == WC_HIGH)
        hi_word <= word;

      if (wclass == WC_IDLE) begin
        state    <= ST_HUNT;
        good_cnt <= '0;
        bad_cnt  <= '0;
        LOCKED   <= 1'b0;
      end else begin
        case (state)
          ST_HUNT: begin
            if (wclass == WC_LOW && !sep_fc) begin
              exp_idx  <= idx_succ(sep_idx);
              good_cnt <= '0;
              state    <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (frame_bad) begin
              SEP_ERR <= sep_mis;
              state   <= ST_HUNT;
            end else if (frame_done) begin
              exp_idx <= idx_succ(exp_idx);
              if (good_cnt + 4'd1 == SYNC_N) begin
                // The frame that completes sync is the first one delivered.
                state        <= ST_LOCK;
                LOCKED       <= 1'b1;
                bad_cnt      <= '0;
                DATA_VALID   <= 1'b1;
                GEM_DATA     <= {hi_word, word[31:8]};
                GEM_OVERFLOW <= sep_fc;
                BX_SEQ       <= exp_idx;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end
          end
          ST_LOCK: begin
            if (frame_bad) begin
              SEP_ERR <= sep_mis;
              if (sep_mis)
                exp_idx <= idx_succ(sep_idx);
              if (ERR_CNT != 16'hFFFF)
                ERR_CNT <= ERR_CNT + 16'd1;
              if (bad_cnt + 4'd1 == LOSS_N) begin
                state   <= ST_HUNT;
                LOCKED  <= 1'b0;
                bad_cnt <= '0;
              end else begin
                bad_cnt <= bad_cnt + 4'd1;
              end
            end else if (frame_done) begin
              exp_idx      <= idx_succ(exp_idx);
              bad_cnt      <= '0;
              DATA_VALID   <= 1'b1;
              GEM_DATA     <= {hi_word, word[31:8]};
              GEM_OVERFLOW <= sep_fc;
              BX_SEQ       <= exp_idx;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gem_fiber_in.sv
// Randomised and directed bench for gem_fiber_in against a word-level frame model.
module tb_gem_fiber_in;

  logic        TRG_CLK80 = 1'b0;
  logic        TRG_RST_N = 1'b0;
  logic [31:0] RX_DATA   = '0;
  logic [3:0]  RX_ISK    = '0;
  logic        RX_ERR    = 1'b0;
  logic [55:0] GEM_DATA;
  logic        GEM_OVERFLOW;
  logic [1:0]  BX_SEQ;
  logic        DATA_VALID;
  logic        LOCKED;
  logic        IDLE;
  logic        SEP_ERR;
  logic [15:0] ERR_CNT;

  localparam int SYNC_N = 4;
  localparam int LOSS_N = 3;

  gem_fiber_in #(.SYNC_FRAMES(SYNC_N), .LOSS_FRAMES(LOSS_N)) dut (
    .TRG_CLK80   (TRG_CLK80),
    .TRG_RST_N   (TRG_RST_N),
    .RX_DATA     (RX_DATA),
    .RX_ISK      (RX_ISK),
    .RX_ERR      (RX_ERR),
    .GEM_DATA    (GEM_DATA),
    .GEM_OVERFLOW(GEM_OVERFLOW),
    .BX_SEQ      (BX_SEQ),
    .DATA_VALID  (DATA_VALID),
    .LOCKED      (LOCKED),
    .IDLE        (IDLE),
    .SEP_ERR     (SEP_ERR),
    .ERR_CNT     (ERR_CNT)
  );

  always #5 TRG_CLK80 = ~TRG_CLK80;

  typedef struct packed {
    logic        vld;
    logic [55:0] dat;
    logic        ovf;
    logic [1:0]  bx;
    logic        lck;
    logic        idl;
    logic        serr;
    logic [15:0] ecnt;
  } obs_t;

  obs_t pipe[$];
  int   total = 0;
  int   bad   = 0;

  localparam int HUNT = 0, SYNC = 1, LOCK = 2;
  localparam logic [31:0] IDLE_W = 32'h50BC50BC;
  logic [7:0] seps [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};

  int          m_mode, m_expect, m_good, m_bad, m_errs;
  bit          m_have_hi;
  logic [31:0] m_hi;
  obs_t        m_hold;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int sep_num(input logic [7:0] b);
    case (b)
      8'hBC:   return 0;
      8'hF7:   return 1;
      8'hFB:   return 2;
      8'hFD:   return 3;
      8'hFC:   return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = HUNT; m_expect = 0; m_good = 0; m_bad = 0; m_errs = 0;
    m_have_hi = 0; m_hi = '0; m_hold = '0;
  endtask

  // Expected outputs two cycles after word (d,k,e) reaches the pins.
  task automatic model_word(input logic [31:0] d, input logic [3:0] k, input logic e, output obs_t o);
    bit is_idle, is_high, is_low, complete, broken;
    int s;
    s        = sep_num(d[7:0]);
    is_idle  = !e && d == IDLE_W && k == 4'b0101;
    is_high  = !e && k == 4'b0000;
    is_low   = !e && k == 4'b0001 && s >= 0;
    complete = 0;
    broken   = 0;
    o        = m_hold;
    o.vld    = 0;
    o.serr   = 0;
    o.idl    = is_idle;
    if (is_idle) begin
      m_mode = HUNT; m_good = 0; m_bad = 0; m_have_hi = 0;
    end else begin
      if (is_high) begin
        broken = m_have_hi;
        m_hi = d;
        m_have_hi = 1;
      end else if (is_low) begin
        complete = m_have_hi;
        broken = !m_have_hi;
        m_have_hi = 0;
      end else begin
        broken = 1;
        m_have_hi = 0;
      end
      if (m_mode == HUNT) begin
        if (is_low && s != 4) begin
          m_expect = (s + 1) % 4; m_good = 0; m_mode = SYNC;
        end
      end else begin
        if (complete && s != 4 && s != m_expect) begin
          o.serr = 1; broken = 1; complete = 0;
          if (m_mode == LOCK) m_expect = (s + 1) % 4;
        end
        if (broken) begin
          if (m_mode == SYNC) m_mode = HUNT;
          else begin
            if (m_errs < 65535) m_errs++;
            m_bad++;
            if (m_bad == LOSS_N) begin m_mode = HUNT; m_bad = 0; end
          end
        end else if (complete) begin
          if (m_mode == SYNC) begin
            m_good++;
            if (m_good == SYNC_N) begin m_mode = LOCK; m_bad = 0; end
          end else m_bad = 0;
          if (m_mode == LOCK) begin
            o.vld = 1;
            o.dat = {m_hi, d[31:8]};
            o.ovf = (s == 4);
            o.bx  = 2'(m_expect);
          end
          m_expect = (m_expect + 1) % 4;
        end
      end
    end
    o.lck  = (m_mode == LOCK);
    o.ecnt = 16'(m_errs);
    if (o.vld) m_hold = o;
  endtask

  task automatic step(input logic [31:0] d, input logic [3:0] k, input logic e);
    obs_t want, o;
    @(posedge TRG_CLK80); #1;
    if (pipe.size() == 2) begin
      want = pipe.pop_front();
      check("data_valid", DATA_VALID, want.vld);
      check("gem_data", GEM_DATA, want.dat);
      check("overflow", GEM_OVERFLOW, want.ovf);
      check("bx_seq", BX_SEQ, want.bx);
      check("locked", LOCKED, want.lck);
      check("idle", IDLE, want.idl);
      check("sep_err", SEP_ERR, want.serr);
      check("err_cnt", ERR_CNT, want.ecnt);
    end
    RX_DATA = d; RX_ISK = k; RX_ERR = e;
    model_word(d, k, e, o);
    pipe.push_back(o);
  endtask

  task automatic do_reset();
    obs_t o;
    @(posedge TRG_CLK80); #1;
    TRG_RST_N = 1'b0;
    @(posedge TRG_CLK80); #1;
    check("rst_valid", DATA_VALID, 0);
    check("rst_data", GEM_DATA, 0);
    check("rst_ovf", GEM_OVERFLOW, 0);
    check("rst_bx", BX_SEQ, 0);
    check("rst_locked", LOCKED, 0);
    check("rst_idle", IDLE, 0);
    check("rst_sep_err", SEP_ERR, 0);
    check("rst_err_cnt", ERR_CNT, 0);
    model_reset();
    pipe.delete();
    pipe.push_back('0);
    TRG_RST_N = 1'b1;
    RX_DATA = IDLE_W; RX_ISK = 4'b0101; RX_ERR = 1'b0;
    model_word(IDLE_W, 4'b0101, 1'b0, o);
    pipe.push_back(o);
  endtask

  task automatic send_frame(input logic [55:0] d, input logic [7:0] sep, input logic err_lo);
    step(d[55:24], 4'b0000, 1'b0);
    step({d[23:0], sep}, 4'b0001, err_lo);
  endtask

  task automatic send_idles(input int n);
    for (int i = 0; i < n; i++) step(IDLE_W, 4'b0101, 1'b0);
  endtask

  initial begin
    logic [55:0] fd;
    logic [63:0] r64;
    int          r, gen, w;
    fd = 56'h0123456789ABCD;

    do_reset();
    send_idles(8);
    // Seed on BC, then four good frames bring lock.
    for (int i = 0; i < 6; i++) send_frame(fd, seps[i % 4], 1'b0);
    check("lock_up", LOCKED, 1);
    check("first_lock_valid", DATA_VALID, 1);

    send_frame(fd, 8'hFC, 1'b0);
    send_frame(fd, 8'hFD, 1'b0);
    check("fc_overflow", GEM_OVERFLOW, 1);
    check("fc_bx", BX_SEQ, 2);
    check("fc_no_sep_err", SEP_ERR, 0);

    send_frame(fd, 8'hBC, 1'b0);
    send_frame(fd, 8'hF7, 1'b0);
    send_frame(fd, 8'hF7, 1'b0);
    send_frame(fd, 8'hFB, 1'b0);
    check("mis_sep_err", SEP_ERR, 1);
    check("mis_no_valid", DATA_VALID, 0);
    check("mis_err_cnt", ERR_CNT, 1);
    send_frame(fd, 8'hFD, 1'b0);
    check("mis_recover_valid", DATA_VALID, 1);
    check("mis_still_locked", LOCKED, 1);

    for (int i = 0; i < 3; i++) send_frame(fd, 8'hBC, 1'b1);
    send_frame(fd, 8'hBC, 1'b0);
    check("loss_unlocked", LOCKED, 0);
    check("loss_err_cnt", ERR_CNT, 4);
    for (int i = 1; i < 5; i++) send_frame(fd, seps[i % 4], 1'b0);
    send_frame(fd, 8'hF7, 1'b0);
    check("relock", LOCKED, 1);

    step(32'hDEADBEEF, 4'b0000, 1'b0);
    send_frame(fd, 8'hFB, 1'b0);
    send_frame(fd, 8'hFD, 1'b0);
    check("xhigh_valid", DATA_VALID, 1);
    check("xhigh_err_cnt", ERR_CNT, 5);

    step(32'h11223344, 4'b0000, 1'b0);
    do_reset();
    send_idles(8);

    gen = 0;
    for (int i = 0; i < 400; i++) begin
      r64 = {$urandom, $urandom};
      fd  = r64[55:0];
      r   = $urandom_range(0, 99);
      if (r < 72) begin
        send_frame(fd, seps[gen], 1'b0); gen = (gen + 1) % 4;
      end else if (r < 80) begin
        send_frame(fd, 8'hFC, 1'b0); gen = (gen + 1) % 4;
      end else if (r < 85) begin
        w = $urandom_range(0, 3);
        send_frame(fd, seps[w], 1'b0); gen = (w + 1) % 4;
      end else if (r < 90) begin
        send_frame(fd, seps[gen], 1'b1);
      end else if (r < 94) begin
        step(r64[63:32], 4'b0000, 1'b0);
        send_frame(fd, seps[gen], 1'b0); gen = (gen + 1) % 4;
      end else if (r < 96) begin
        step({fd[23:0], seps[gen]}, 4'b0001, 1'b0);
      end else if (r < 98) begin
        step(fd[31:0], 4'b1000, 1'b0);
      end else begin
        step(IDLE_W, 4'b0101, 1'b0);
      end
    end
    send_idles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
